// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path: widths, reset address,
// the NOP encoding, the request-tracking state encoding and the buffer entry.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    // Request tracking: nothing in flight, one live request, one killed request
    typedef enum logic [1:0] {
        FETCH_IDLE      = 2'd0,
        FETCH_WAIT      = 2'd1,
        FETCH_WAIT_KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {addr, instr}. Flush wins over push;
// a push into a full buffer is accepted only when a pop happens alongside it.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    // Next pointers and occupancy from the accepted push/pop and flush
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_pop)  rd_ptr_d = ~rd_ptr_q;
            if (do_push) wr_ptr_d = ~wr_ptr_q;
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word request at a time, buffers up to
// two returned instructions, and on a taken redirect flushes the buffer, drops
// any in-flight response and restarts fetching at the target.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            run_q;

    logic            transfer, redirect, gnt_fire, live_rsp, outstanding;
    logic [1:0]      slots_used;
    logic            fifo_push;
    fetch_entry_t    fifo_in, fifo_head;
    logic            fifo_full, fifo_empty;
    logic [1:0]      fifo_count;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (transfer),
        .flush     (redirect),
        .push_data (fifo_in),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Handshake decode; only one request may be in flight, and a live
    // response arriving together with a redirect is thrown away
    always_comb begin
        outstanding = (state_q != FETCH_IDLE);
        slots_used  = fifo_count + {1'b0, outstanding};
        imem_req    = run_q && !outstanding && (slots_used < 2'd2);
        transfer    = instr_valid && instr_ready;
        redirect    = transfer && PCSrc;
        gnt_fire    = imem_req && imem_gnt;
        live_rsp    = (state_q == FETCH_WAIT) && imem_rvalid;
        fifo_push   = live_rsp && !redirect && (!fifo_full || transfer);
        fifo_in     = '{addr: req_addr_q, instr: imem_rdata};
    end

    // Next fetch address, in-flight address and request-tracking state
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        state_d    = state_q;
        if (gnt_fire) begin
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect) begin
            fetch_pc_d = word_align(PCTarget);
        end
        case (state_q)
            FETCH_IDLE: begin
                if (gnt_fire) state_d = redirect ? FETCH_WAIT_KILL : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (gnt_fire) state_d = redirect ? FETCH_WAIT_KILL : FETCH_WAIT;
                    else          state_d = FETCH_IDLE;
                end else if (redirect) begin
                    state_d = FETCH_WAIT_KILL;
                end
            end
            FETCH_WAIT_KILL: begin
                if (imem_rvalid) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    // Request FSM and fetch address registers; run_q holds requests off
    // until the first clock edge after reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= word_align(RESET_PC);
            req_addr_q <= word_align(RESET_PC);
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            run_q      <= 1'b1;
        end
    end

    // Consumer view: buffer head, or NOP at the next address to be delivered
    always_comb begin
        instr_valid = !fifo_empty;
        imem_addr   = fetch_pc_q;
        if (instr_valid) begin
            Instr = fifo_head.instr;
            PC    = fifo_head.addr;
        end else begin
            Instr = INSTR_NOP;
            PC    = (state_q == FETCH_WAIT) ? req_addr_q : fetch_pc_q;
        end
        PCPlus4 = PC + 32'd4;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a simple memory responder with programmable latency,
// directed scenarios, and a scoreboard checked by an independent monitor.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5C3_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   lat      = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Memory: grant sampled mid-cycle, response after lat cycles, data = addr ^ KEY
    logic        gsamp = 1'b0;
    logic [31:0] gaddr = '0;
    initial begin
        forever begin
            @(negedge clk);
            gsamp = imem_req && imem_gnt;
            gaddr = imem_addr;
        end
    end

    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend        = 1'b0;
        cnt         = 0;
        paddr       = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (gsamp) begin
                pend  = 1'b1;
                paddr = gaddr;
                cnt   = lat;
            end
            if (pend) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = paddr ^ KEY;
                    pend        = 1'b0;
                end
            end
        end
    end

    // Monitor: every accepted instruction is compared against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_instr_pc", PC, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pc", PC, e.pc);
                    check("mon_instr", Instr, e.instr);
                    check("mon_pcplus4", PCPlus4, e.pc + 32'd4);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = '0;
        imem_gnt    = 1'b1;
        lat         = 1;
        repeat (5) tick();
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        bit done;
        done        = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (exp_q.size() == 0) done = 1'b1;
        end
        instr_ready = 1'b0;
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = '0;
        imem_gnt    = 1'b1;

        // Reset values
        do_reset();
        sample();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", Instr, NOP);
        check("rst_pc", PC, 32'h0);
        check("rst_pcplus4", PCPlus4, 32'h4);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming with ready held high: one instruction every two cycles
        tick();
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        instr_ready = 1'b1;
        rst_n       = 1'b1;
        for (int n = 0; n < 8; n++) begin
            sample();
            check("A_req", 32'(imem_req), 32'(n % 2 == 1));
            check("A_valid", 32'(instr_valid), 32'(n >= 3 && n % 2 == 1));
            if (n % 2 == 1) check("A_addr", imem_addr, 32'(2 * (n - 1)));
            tick();
        end
        instr_ready = 1'b0;
        check("A_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure: two buffered, requests stop, nothing lost
        do_reset();
        rst_n = 1'b1;
        repeat (12) tick();
        sample();
        check("B_req", 32'(imem_req), 32'd0);
        check("B_valid", 32'(instr_valid), 32'd1);
        check("B_pc", PC, 32'h0);
        check("B_instr", Instr, KEY);
        check("B_addr", imem_addr, 32'h8);
        tick();
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        drain("B_drain");

        // Redirect at PC=4 while the request for 8 is still in flight
        do_reset();
        rst_n = 1'b1;
        repeat (6) tick();
        lat = 3;
        instr_ready = 1'b1;
        exp_push(32'h0);
        tick();
        instr_ready = 1'b0;
        tick();
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h0000_0103;
        exp_push(32'h4);
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        sample();
        check("C_valid_flushed", 32'(instr_valid), 32'd0);
        check("C_req_killwait", 32'(imem_req), 32'd0);
        check("C_addr", imem_addr, 32'h0000_0100);
        tick();
        tick();
        sample();
        check("C_req_resume", 32'(imem_req), 32'd1);
        check("C_addr_resume", imem_addr, 32'h0000_0100);
        lat = 1;
        tick();
        exp_push(32'h0000_0100);
        drain("C_drain");

        // Response and redirect in the same cycle: response discarded
        do_reset();
        rst_n = 1'b1;
        repeat (6) tick();
        instr_ready = 1'b1;
        exp_push(32'h0);
        tick();
        instr_ready = 1'b0;
        tick();
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h0000_0200;
        exp_push(32'h4);
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        sample();
        check("D_valid", 32'(instr_valid), 32'd0);
        check("D_req", 32'(imem_req), 32'd1);
        check("D_addr", imem_addr, 32'h0000_0200);
        tick();
        exp_push(32'h0000_0200);
        drain("D_drain");

        // Address wrap at the top of memory, target low bits ignored
        do_reset();
        rst_n = 1'b1;
        repeat (6) tick();
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'hFFFF_FFFF;
        exp_push(32'h0);
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        sample();
        check("E_req", 32'(imem_req), 32'd1);
        check("E_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        sample();
        check("E_addr_wrap", imem_addr, 32'h0);
        tick();
        sample();
        check("E_valid", 32'(instr_valid), 32'd1);
        check("E_pc", PC, 32'hFFFF_FFFC);
        check("E_pcplus4", PCPlus4, 32'h0);
        check("E_instr", Instr, 32'hFFFF_FFFC ^ KEY);
        tick();
        exp_push(32'hFFFF_FFFC);
        drain("E_drain");

        // Reset mid-transaction, stray response after release
        do_reset();
        rst_n = 1'b1;
        repeat (3) tick();
        lat = 4;
        tick();
        rst_n = 1'b0;
        #1;
        check("F_req", 32'(imem_req), 32'd0);
        check("F_valid", 32'(instr_valid), 32'd0);
        check("F_instr", Instr, NOP);
        check("F_pc", PC, 32'h0);
        check("F_pcplus4", PCPlus4, 32'h4);
        check("F_addr", imem_addr, 32'h0);
        imem_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        sample();
        check("F_stray_valid", 32'(instr_valid), 32'd0);
        check("F_stray_req", 32'(imem_req), 32'd1);
        check("F_stray_addr", imem_addr, 32'h0);
        tick();
        lat      = 1;
        imem_gnt = 1'b1;
        exp_push(32'h0);
        drain("F_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
